// File: rtl/edit_input_conditioner.sv
// Debounces active-low buttons and switches; emits press and auto-repeat pulses. Latency: level and press
// appear DEBOUNCE_CYCLES+2 cycles after the raw change; no backpressure, pulses are one-cycle and unconditional.
module edit_input_conditioner #(
    parameter int N_BTN           = 3,
    parameter int N_SW            = 3,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic [N_BTN-1:0] btn_raw_n,
    input  logic [N_SW-1:0]  sw_raw,
    output logic [N_BTN-1:0] btn_edit_export,
    output logic [N_SW-1:0]  sw_states_export,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_repeat
);
    localparam int N_CH = N_BTN + N_SW;
    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HW   = $clog2(HMAX + 1);

    localparam logic [DW-1:0] C_DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] C_RD      = HW'(REPEAT_DELAY);
    localparam logic [HW-1:0] C_RP      = HW'(REPEAT_PERIOD);

    typedef enum logic [1:0] {
        S_RELEASED,
        S_HELD_DELAY,
        S_HELD_REPEAT
    } state_t;

    logic [N_BTN-1:0] r_btn_s1, r_btn_s2;
    logic [N_SW-1:0]  r_sw_s1, r_sw_s2;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_btn_s1 <= '1;
            r_btn_s2 <= '1;
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
        end else begin
            r_btn_s1 <= btn_raw_n;
            r_btn_s2 <= r_btn_s1;
            r_sw_s1  <= sw_raw;
            r_sw_s2  <= r_sw_s1;
        end
    end

    // Buttons and switches share one debounce bank; buttons occupy the low channels, 1 = pressed.
    logic [N_CH-1:0] w_in;
    logic [N_CH-1:0] r_stable;
    logic [N_CH-1:0] w_stable_nxt;
    logic [DW-1:0]   r_cnt     [N_CH];
    logic [DW-1:0]   w_cnt_nxt [N_CH];

    assign w_in = {r_sw_s2, ~r_btn_s2};

    always_comb begin
        w_stable_nxt = r_stable;
        for (int i = 0; i < N_CH; i++) begin
            w_cnt_nxt[i] = '0;
            if (w_in[i] != r_stable[i]) begin
                if (r_cnt[i] == C_DB_LAST) w_stable_nxt[i] = w_in[i];
                else                       w_cnt_nxt[i]    = r_cnt[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_stable <= '0;
            for (int i = 0; i < N_CH; i++) r_cnt[i] <= '0;
        end else begin
            r_stable <= w_stable_nxt;
            for (int i = 0; i < N_CH; i++) r_cnt[i] <= w_cnt_nxt[i];
        end
    end

    assign btn_edit_export  = r_stable[N_BTN-1:0];
    assign sw_states_export = r_stable[N_CH-1:N_BTN];

    // The FSM follows the next stable value so the press pulse lands in the same cycle as the level.
    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        state_t        r_state, w_state_nxt;
        logic [HW-1:0] r_hold, w_hold_nxt, w_hold_inc;
        logic          r_press, w_press_nxt;
        logic          r_rep, w_rep_nxt;

        assign w_hold_inc = r_hold + 1'b1;

        always_ff @(posedge clk_clk or posedge reset_reset) begin
            if (reset_reset) begin
                r_state <= S_RELEASED;
                r_hold  <= '0;
                r_press <= 1'b0;
                r_rep   <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_hold  <= w_hold_nxt;
                r_press <= w_press_nxt;
                r_rep   <= w_rep_nxt;
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_hold_nxt  = r_hold;
            w_press_nxt = 1'b0;
            w_rep_nxt   = 1'b0;
            if (!w_stable_nxt[g]) begin
                w_state_nxt = S_RELEASED;
                w_hold_nxt  = '0;
            end else begin
                case (r_state)
                    S_RELEASED: begin
                        w_state_nxt = S_HELD_DELAY;
                        w_hold_nxt  = '0;
                        w_press_nxt = 1'b1;
                    end
                    S_HELD_DELAY: begin
                        if (r_hold == C_RD) begin
                            w_hold_nxt = r_hold;
                        end else if (w_hold_inc == C_RD) begin
                            if (REPEAT_EN != 0) begin
                                w_rep_nxt   = 1'b1;
                                w_state_nxt = S_HELD_REPEAT;
                                w_hold_nxt  = '0;
                            end else begin
                                w_hold_nxt  = C_RD;
                            end
                        end else begin
                            w_hold_nxt = w_hold_inc;
                        end
                    end
                    S_HELD_REPEAT: begin
                        if (w_hold_inc == C_RP) begin
                            w_rep_nxt  = 1'b1;
                            w_hold_nxt = '0;
                        end else begin
                            w_hold_nxt = w_hold_inc;
                        end
                    end
                    default: begin
                        w_state_nxt = S_RELEASED;
                        w_hold_nxt  = '0;
                    end
                endcase
            end
        end

        assign btn_press[g]  = r_press;
        assign btn_repeat[g] = r_rep;
    end

endmodule

// File: tb/tb_edit_input_conditioner.sv
module tb_edit_input_conditioner;
    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] btn_raw_n = 3'b111;
    logic [2:0] sw_raw = 3'b000;
    logic [2:0] edit1, sw1, press1, rep1;
    logic [2:0] edit0, sw0, press0, rep0;

    int checks = 0;
    int failures = 0;
    int pcnt [3] = '{0, 0, 0};
    int rcnt [3] = '{0, 0, 0};
    int rcnt0 = 0;

    always #5 clk = ~clk;

    edit_input_conditioner #(
        .N_BTN(3), .N_SW(3), .DEBOUNCE_CYCLES(D),
        .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) u_dut (
        .clk_clk(clk), .reset_reset(rst), .btn_raw_n(btn_raw_n), .sw_raw(sw_raw),
        .btn_edit_export(edit1), .sw_states_export(sw1),
        .btn_press(press1), .btn_repeat(rep1)
    );

    edit_input_conditioner #(
        .N_BTN(3), .N_SW(3), .DEBOUNCE_CYCLES(D),
        .REPEAT_EN(0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) u_dut_norep (
        .clk_clk(clk), .reset_reset(rst), .btn_raw_n(btn_raw_n), .sw_raw(sw_raw),
        .btn_edit_export(edit0), .sw_states_export(sw0),
        .btn_press(press0), .btn_repeat(rep0)
    );

    // Pulse tallies, sampled mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (press1[i] === 1'b1) pcnt[i]++;
            if (rep1[i] === 1'b1)   rcnt[i]++;
            if (rep0[i] === 1'b1)   rcnt0++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [2:0] el, ep;
        btn_raw_n = 3'b000;
        sw_raw    = 3'b111;
        rst       = 1'b1;
        repeat (3) tick();
        checks++;
        if ({edit1, sw1, press1, rep1, edit0, sw0, press0, rep0} !== 24'h0) begin
            failures++;
            $display("FAIL reset_hold got=%h exp=000000", {edit1, sw1, press1, rep1, edit0, sw0, press0, rep0});
        end
        for (int pass = 0; pass < 2; pass++) begin
            rst = 1'b0;
            for (int n = 1; n <= 8; n++) begin
                tick();
                el = (n >= 6) ? 3'b111 : 3'b000;
                ep = (n == 6) ? 3'b111 : 3'b000;
                checks++;
                if (edit1 !== el || sw1 !== el || press1 !== ep || rep1 !== 3'b000 || press0 !== ep) begin
                    failures++;
                    $display("FAIL reset_release pass=%0d n=%0d edit=%b sw=%b press=%b rep=%b exp lvl=%b press=%b rep=000",
                             pass, n, edit1, sw1, press1, rep1, el, ep);
                end
            end
            if (pass == 0) begin
                rst = 1'b1;
                repeat (2) tick();
                checks++;
                if ({edit1, sw1, press1, rep1} !== 12'h0) begin
                    failures++;
                    $display("FAIL reset_mid got=%h exp=000", {edit1, sw1, press1, rep1});
                end
            end
        end
        btn_raw_n = 3'b111;
        sw_raw    = 3'b000;
        repeat (8) tick();
        checks++;
        if (edit1 !== 3'b000 || sw1 !== 3'b000 || rcnt[0] + rcnt[1] + rcnt[2] != 0) begin
            failures++;
            $display("FAIL reset_idle edit=%b sw=%b repeats=%0d exp 000 000 0", edit1, sw1, rcnt[0] + rcnt[1] + rcnt[2]);
        end
    endtask

    task automatic test_clean_press();
        int p0 [3];
        logic [2:0] el, ep;
        for (int i = 0; i < 3; i++) p0[i] = pcnt[i];
        btn_raw_n[0] = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            tick();
            el = (n >= 6) ? 3'b001 : 3'b000;
            ep = (n == 6) ? 3'b001 : 3'b000;
            checks++;
            if (edit1 !== el || press1 !== ep || rep1 !== 3'b000) begin
                failures++;
                $display("FAIL clean_press n=%0d edit=%b press=%b rep=%b exp %b %b 000", n, edit1, press1, rep1, el, ep);
            end
        end
        btn_raw_n[0] = 1'b1;
        repeat (8) tick();
        checks++;
        if (edit1 !== 3'b000 || pcnt[0] - p0[0] != 1 || pcnt[1] != p0[1] || pcnt[2] != p0[2]) begin
            failures++;
            $display("FAIL clean_release edit=%b press_counts=%0d,%0d,%0d exp 000 1,0,0",
                     edit1, pcnt[0] - p0[0], pcnt[1] - p0[1], pcnt[2] - p0[2]);
        end
    endtask

    task automatic test_bounce();
        logic [13:0] pat;
        int p1;
        logic [2:0] el, ep;
        pat = 14'b11111110001000;
        p1  = pcnt[1];
        for (int n = 0; n < 14; n++) begin
            btn_raw_n[1] = pat[n];
            tick();
            checks++;
            if (edit1 !== 3'b000 || press1 !== 3'b000) begin
                failures++;
                $display("FAIL bounce_reject n=%0d edit=%b press=%b exp 000 000", n, edit1, press1);
            end
        end
        btn_raw_n[1] = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            tick();
            el = (n >= 6) ? 3'b010 : 3'b000;
            ep = (n == 6) ? 3'b010 : 3'b000;
            checks++;
            if (edit1 !== el || press1 !== ep) begin
                failures++;
                $display("FAIL bounce_accept n=%0d edit=%b press=%b exp %b %b", n, edit1, press1, el, ep);
            end
        end
        btn_raw_n[1] = 1'b1;
        repeat (8) tick();
        checks++;
        if (pcnt[1] - p1 != 1 || edit1 !== 3'b000) begin
            failures++;
            $display("FAIL bounce_once presses=%0d edit=%b exp 1 000", pcnt[1] - p1, edit1);
        end
    endtask

    task automatic test_auto_repeat();
        logic [2:0] er, ee;
        btn_raw_n[2] = 1'b0;
        repeat (6) tick();
        checks++;
        if (press1 !== 3'b100 || edit1 !== 3'b100 || press0 !== 3'b100) begin
            failures++;
            $display("FAIL repeat_press press=%b edit=%b press_norep=%b exp 100 100 100", press1, edit1, press0);
        end
        for (int n = 1; n <= 40; n++) begin
            tick();
            er = (n >= RD && n < 36 && (n - RD) % RP == 0) ? 3'b100 : 3'b000;
            ee = (n < 36) ? 3'b100 : 3'b000;
            checks++;
            if (rep1 !== er || edit1 !== ee || edit0 !== ee || press1 !== 3'b000 || rep0 !== 3'b000) begin
                failures++;
                $display("FAIL repeat_cadence n=%0d rep=%b edit=%b edit_norep=%b press=%b rep_norep=%b exp %b %b %b 000 000",
                         n, rep1, edit1, edit0, press1, rep0, er, ee, ee);
            end
            if (n == 30) btn_raw_n[2] = 1'b1;
        end
        checks++;
        if (rcnt0 != 0 || rcnt[2] != 9) begin
            failures++;
            $display("FAIL repeat_totals norep=%0d rep2=%0d exp 0 9", rcnt0, rcnt[2]);
        end
    endtask

    task automatic test_simultaneous();
        logic [2:0] er, ee, ep;
        btn_raw_n = 3'b010;
        for (int n = 1; n <= 6; n++) begin
            tick();
            ep = (n == 6) ? 3'b101 : 3'b000;
            checks++;
            if (press1 !== ep) begin
                failures++;
                $display("FAIL simul_press n=%0d press=%b exp %b", n, press1, ep);
            end
        end
        for (int n = 1; n <= 24; n++) begin
            tick();
            er = 3'b000;
            if (n >= RD && (n - RD) % RP == 0) er = (n < 18) ? 3'b101 : 3'b100;
            ee = (n < 18) ? 3'b101 : 3'b100;
            checks++;
            if (rep1 !== er || edit1 !== ee || press1 !== 3'b000) begin
                failures++;
                $display("FAIL simul_cadence n=%0d rep=%b edit=%b press=%b exp %b %b 000", n, rep1, edit1, press1, er, ee);
            end
            if (n == 12) btn_raw_n[0] = 1'b1;
        end
        btn_raw_n = 3'b111;
        repeat (10) tick();
        checks++;
        if (edit1 !== 3'b000) begin
            failures++;
            $display("FAIL simul_release edit=%b exp 000", edit1);
        end
    endtask

    task automatic test_switch();
        int pt, rt;
        logic [2:0] es;
        pt = pcnt[0] + pcnt[1] + pcnt[2];
        rt = rcnt[0] + rcnt[1] + rcnt[2];
        for (int n = 0; n < 14; n++) begin
            sw_raw[2] = (n < 2 || n >= 4);
            tick();
            es = (n + 1 >= 10) ? 3'b100 : 3'b000;
            checks++;
            if (sw1 !== es || sw0 !== es || press1 !== 3'b000 || rep1 !== 3'b000) begin
                failures++;
                $display("FAIL switch_debounce n=%0d sw=%b sw_norep=%b press=%b rep=%b exp %b %b 000 000",
                         n + 1, sw1, sw0, press1, rep1, es, es);
            end
        end
        checks++;
        if (pcnt[0] + pcnt[1] + pcnt[2] != pt || rcnt[0] + rcnt[1] + rcnt[2] != rt) begin
            failures++;
            $display("FAIL switch_no_events presses=%0d repeats=%0d exp %0d %0d",
                     pcnt[0] + pcnt[1] + pcnt[2], rcnt[0] + rcnt[1] + rcnt[2], pt, rt);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_simultaneous();
        test_switch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
